// File: rtl/muldiv_sequencer_if.sv
// CPU-side request/response bundle for muldiv_sequencer.
// MULDIV_ABORT_EN adds the abort (flush) request line.
interface muldiv_sequencer_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         hilo_we;
  logic         hilo_sel;
  logic [W-1:0] hilo_wdata;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
`ifdef MULDIV_ABORT_EN
  logic         abort;

  modport master (
    output start, op, a_in, b_in, hilo_we, hilo_sel, hilo_wdata, abort,
    input  busy, done, div0, hi_q, lo_q
  );
  modport slave (
    input  start, op, a_in, b_in, hilo_we, hilo_sel, hilo_wdata, abort,
    output busy, done, div0, hi_q, lo_q
  );
`else
  modport master (
    output start, op, a_in, b_in, hilo_we, hilo_sel, hilo_wdata,
    input  busy, done, div0, hi_q, lo_q
  );
  modport slave (
    input  start, op, a_in, b_in, hilo_we, hilo_sel, hilo_wdata,
    output busy, done, div0, hi_q, lo_q
  );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative MULT/DIV units and owns architectural HI/LO.
// Optional MULDIV_ABORT_EN: abort input flushes an operation in CLR/RUN.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int W           = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   bus,
  input  logic [W-1:0]        mult_hi,
  input  logic [W-1:0]        mult_lo,
  input  logic [W-1:0]        div_hi,
  input  logic [W-1:0]        div_lo,
  output logic [W-1:0]        op_a,
  output logic [W-1:0]        op_b,
  output logic                mult_rst,
  output logic                mult_ctrl,
  output logic                div_rst,
  output logic                div_ctrl
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_CAPTURE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            w_accept;
  logic            w_div0;
  logic            w_abort;

  always_comb begin
    w_accept = bus.start && ((bus.op == 2'b00) || ((bus.op == 2'b01) && (bus.b_in != '0)));
    w_div0   = bus.start && (bus.op == 2'b01) && (bus.b_in == '0);
`ifdef MULDIV_ABORT_EN
    w_abort  = bus.abort;
`else
    w_abort  = 1'b0;
`endif
  end

  // Unit clears are registered 1 during reset so both units stay cleared until the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      mult_rst   <= 1'b1;
      div_rst    <= 1'b1;
      mult_ctrl  <= 1'b0;
      div_ctrl   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.div0   <= 1'b0;
      bus.hi_q   <= '0;
      bus.lo_q   <= '0;
    end else begin
      mult_rst <= 1'b0;
      div_rst  <= 1'b0;
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hilo_we) begin
            if (bus.hilo_sel) bus.hi_q <= bus.hilo_wdata;
            else              bus.lo_q <= bus.hilo_wdata;
          end
          if (w_accept) begin
            op_a     <= bus.a_in;
            op_b     <= bus.b_in;
            r_is_div <= bus.op[0];
            r_cnt    <= bus.op[0] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            mult_rst <= ~bus.op[0];
            div_rst  <= bus.op[0];
            bus.busy <= 1'b1;
            r_state  <= S_CLR;
          end else if (w_div0) begin
            bus.div0 <= 1'b1;
          end
        end
        S_CLR, S_RUN: begin
          if (w_abort) begin
            mult_rst  <= ~r_is_div;
            div_rst   <= r_is_div;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            bus.busy  <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else if (r_state == S_CLR) begin
            mult_ctrl <= ~r_is_div;
            div_ctrl  <= r_is_div;
            r_state   <= S_RUN;
          end else begin
            // Leaving on count==1 keeps ctrl high for exactly N cycles.
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              mult_ctrl <= 1'b0;
              div_ctrl  <= 1'b0;
              bus.done  <= 1'b1;
              r_state   <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          bus.hi_q <= r_is_div ? div_hi : mult_hi;
          bus.lo_q <= r_is_div ? div_lo : mult_lo;
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random MULT/DIV/div0/HI-LO traffic
// against arithmetic expectations, with iterative unit stand-ins that only yield a good result after exactly N enables.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.W(W)) bus();
  logic [W-1:0] op_a, op_b, mult_hi, mult_lo, div_hi, div_lo;
  logic mult_rst, mult_ctrl, div_rst, div_ctrl;

  muldiv_sequencer #(.MULT_CYCLES(N), .DIV_CYCLES(N), .W(W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .op_a(op_a), .op_b(op_b),
    .mult_rst(mult_rst), .mult_ctrl(mult_ctrl), .div_rst(div_rst), .div_ctrl(div_ctrl)
  );

  // Unit stand-ins: result is correct only when enable was seen exactly N times since clear.
  int unsigned mcnt, dcnt;
  always @(posedge clk) begin
    if (mult_rst) mcnt <= 0; else if (mult_ctrl) mcnt <= mcnt + 1;
    if (div_rst)  dcnt <= 0; else if (div_ctrl)  dcnt <= dcnt + 1;
  end
  logic [63:0] w_prod;
  logic [31:0] w_q, w_r;
  always_comb begin
    w_prod = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    w_q = '0;
    w_r = '0;
    if (op_b != '0) begin
      w_q = $signed(op_a) / $signed(op_b);
      w_r = $signed(op_a) % $signed(op_b);
    end
    mult_hi = (mcnt == N) ? w_prod[63:32] : ~w_prod[63:32];
    mult_lo = (mcnt == N) ? w_prod[31:0]  : ~w_prod[31:0];
    div_hi  = (dcnt == N) ? w_r : ~w_r;
    div_lo  = (dcnt == N) ? w_q : ~w_q;
  end

  int unsigned n_mrst, n_mctrl, n_drst, n_dctrl, n_busy, n_done, n_div0;
  always @(negedge clk) begin
    if (mult_rst)  n_mrst++;
    if (mult_ctrl) n_mctrl++;
    if (div_rst)   n_drst++;
    if (div_ctrl)  n_dctrl++;
    if (bus.busy)  n_busy++;
    if (bus.done)  n_done++;
    if (bus.div0)  n_div0++;
  end

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_hi, exp_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hilo_write(input logic sel, input logic [31:0] data);
    @(negedge clk);
    bus.hilo_we = 1'b1; bus.hilo_sel = sel; bus.hilo_wdata = data;
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    if (sel) exp_hi = data; else exp_lo = data;
    chk("hilo_write", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
  endtask

  // we_mode: 0 none, 1 direct write together with start, 2 direct write attempt during RUN
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int we_mode, input bit hold);
    int unsigned s_mrst, s_mctrl, s_drst, s_dctrl, s_busy, s_done, s_div0;
    int k;
    bit got;
    bit isdiv;
    logic wsel;
    logic [31:0] wd;
    longint pa, pb, prod;
    int ia, ib;
    isdiv = op[0];
    wd = $urandom;
    wsel = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
    if (we_mode == 1) begin
      bus.hilo_we = 1'b1; bus.hilo_sel = wsel; bus.hilo_wdata = wd;
    end
    @(posedge clk); #1;
    s_mrst = n_mrst; s_mctrl = n_mctrl; s_drst = n_drst; s_dctrl = n_dctrl;
    s_busy = n_busy; s_done = n_done; s_div0 = n_div0;
    if (!hold) bus.start = 1'b0;
    bus.hilo_we = 1'b0;
    chk("accept_busy", 64'(bus.busy), 64'(1));
    chk("op_a", 64'(op_a), 64'(a));
    chk("op_b", 64'(op_b), 64'(b));
    if (we_mode == 1) begin
      if (wsel) exp_hi = wd; else exp_lo = wd;
      chk("we_with_start", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
    end
    k = 0; got = 1'b0;
    while (!got && k < N + 10) begin
      @(negedge clk);
      k++;
      if (we_mode == 2 && k == 5) begin
        bus.hilo_we = 1'b1; bus.hilo_sel = wsel; bus.hilo_wdata = wd;
      end
      if (we_mode == 2 && k == 6) begin
        bus.hilo_we = 1'b0;
        chk("we_ignored_busy", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
      end
      got = bus.done;
    end
    chk("done_latency", 64'(k), 64'(N + 2));
    @(posedge clk); #1;
    if (isdiv) begin
      ia = a; ib = b;
      exp_lo = 32'(ia / ib);
      exp_hi = 32'(ia % ib);
    end else begin
      pa = longint'($signed(a)); pb = longint'($signed(b));
      prod = pa * pb;
      exp_hi = prod[63:32];
      exp_lo = prod[31:0];
    end
    chk("hilo_result", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
    chk("busy_after", 64'(bus.busy), 64'(0));
    chk("busy_cycles", 64'(n_busy - s_busy), 64'(N + 2));
    chk("done_pulses", 64'(n_done - s_done), 64'(1));
    chk("div0_none", 64'(n_div0 - s_div0), 64'(0));
    chk("sel_ctrl_cycles", 64'(isdiv ? n_dctrl - s_dctrl : n_mctrl - s_mctrl), 64'(N));
    chk("sel_rst_cycles", 64'(isdiv ? n_drst - s_drst : n_mrst - s_mrst), 64'(1));
    chk("other_unit_idle", 64'(isdiv ? (n_mctrl - s_mctrl) + (n_mrst - s_mrst)
                                    : (n_dctrl - s_dctrl) + (n_drst - s_drst)), 64'(0));
  endtask

  // Requests that must get no unit activity: divide-by-zero or reserved op.
  task automatic idle_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s_ctl;
    bit exp_div0;
    exp_div0 = (op == 2'b01) && (b == '0);
    s_ctl = n_mctrl + n_dctrl + n_mrst + n_drst + n_busy;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("div0_pulse", 64'(bus.div0), 64'(exp_div0));
    chk("idle_unit_rst", 64'({mult_rst, div_rst}), 64'(0));
    @(posedge clk); #1;
    chk("div0_clear", 64'(bus.div0), 64'(0));
    chk("idle_hilo", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
    @(negedge clk);
    chk("idle_no_activity", 64'(n_mctrl + n_dctrl + n_mrst + n_drst + n_busy), 64'(s_ctl));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s_done;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = 2'b00; bus.a_in = '0; bus.b_in = '0;
    bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.hilo_wdata = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({bus.busy, bus.done, bus.div0, mult_ctrl, div_ctrl, mult_rst, div_rst}),
        64'(7'b0000011));
    chk("reset_hilo", 64'({bus.hi_q, bus.lo_q}), 64'(0));
    chk("reset_ops", 64'({op_a, op_b}), 64'(0));
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("unit_rst_release", 64'({mult_rst, div_rst}), 64'(0));

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    chk("mult_7x-3", 64'({bus.hi_q, bus.lo_q}), 64'h FFFF_FFFF_FFFF_FFEB);

    idle_op(2'b01, 32'd100, 32'd0);

    run_op(2'b01, 32'd100, 32'd7, 0, 1'b1);
    run_op(2'b01, 32'd100, 32'd7, 0, 1'b0);
    chk("div_100_7", 64'({bus.hi_q, bus.lo_q}), {32'd2, 32'd14});

    idle_op(2'b10, 32'd5, 32'd6);
    idle_op(2'b11, 32'd5, 32'd0);

    hilo_write(1'b0, 32'h0000_1234);
    run_op(2'b00, $urandom, $urandom, 2, 1'b0);
    run_op(2'b01, 32'hFFFF_FF9C, 32'd7, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 1) == 1) hilo_write(1'($urandom_range(0, 1)), $urandom);
      case ($urandom_range(0, 3))
        0: run_op(2'b00, ra, rb, 0, 1'b0);
        1: begin
          if (rb == '0 || (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) rb = 32'd3;
          run_op(2'b01, ra, rb, 0, 1'b0);
        end
        2: idle_op(2'b01, ra, 32'd0);
        default: idle_op(2'($urandom_range(2, 3)), ra, rb);
      endcase
    end

    // Asynchronous reset in RUN cycle 10.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a_in = $urandom; bus.b_in = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s_done = n_done;
    repeat (11) @(negedge clk);
    chk("pre_reset_run", 64'(mult_ctrl), 64'(1));
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_ctrl_busy", 64'({mult_ctrl, bus.busy}), 64'(0));
    chk("rst_mid_mult_rst", 64'(mult_rst), 64'(1));
    chk("rst_mid_hilo", 64'({bus.hi_q, bus.lo_q}), 64'(0));
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_units", 64'({mult_rst, div_rst}), 64'(0));
    repeat (40) @(negedge clk);
    chk("rst_no_done", 64'(n_done - s_done), 64'(0));
    chk("rst_idle", 64'(bus.busy), 64'(0));
    run_op(2'b00, $urandom, $urandom, 0, 1'b0);

`ifdef MULDIV_ABORT_EN
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a_in = $urandom; bus.b_in = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s_done = n_done;
    repeat (6) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy_ctrl", 64'({bus.busy, mult_ctrl}), 64'(0));
    chk("abort_mult_rst", 64'(mult_rst), 64'(1));
    @(posedge clk); #1;
    chk("abort_rst_drop", 64'(mult_rst), 64'(0));
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(n_done - s_done), 64'(0));
    chk("abort_hilo", 64'({bus.hi_q, bus.lo_q}), 64'({exp_hi, exp_lo}));
    run_op(2'b00, $urandom, $urandom, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
